div_detect: RTL and testbench

DIV_DETECT -- requirements
Module: div_detect

---
 rtl/div_detect.sv | 121 ++++++++++++
 tb/tb_div_detect.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_detect.sv
// Measures the half-period of an asynchronous divided clock in clk cycles (div_out = cycles - 1).
// Optional lock detector compiled in with `define DIV_DETECT_LOCK_EN; otherwise locked is tied low.
module div_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clkd_in,
    output logic [10:0] div_out,
    output logic        valid,
    output logic        timeout,
    output logic        busy,
    output logic        locked
);
    localparam logic [10:0] CNT_MAX = 11'h7ff;

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic [1:0]             edge_pipe;
    logic [10:0]            cnt;
    logic                   edg;
    logic                   meas_upd;
    logic                   meas_tmo;

    // Two edge flops after the detector put valid SYNC_STAGES+2 cycles behind the sampling edge.
    assign edg      = edge_pipe[1];
    assign meas_upd = en && (state == MEAS) && edg;
    assign meas_tmo = en && (state == MEAS) && !edg && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            dly_q     <= 1'b0;
            edge_pipe <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], clkd_in};
            dly_q     <= sync_q[SYNC_STAGES-1];
            edge_pipe <= {edge_pipe[0], sync_q[SYNC_STAGES-1] ^ dly_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_out <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                timeout <= 1'b0;
                busy    <= 1'b0;
            end else begin
                busy <= 1'b1;
                case (state)
                    IDLE: begin
                        state <= ARM;
                        cnt   <= '0;
                    end
                    ARM: begin
                        cnt <= '0;
                        if (edg) state <= MEAS;
                    end
                    MEAS: begin
                        // An edge on the terminal count still wins over the timeout.
                        if (meas_upd) begin
                            div_out <= cnt;
                            valid   <= 1'b1;
                            cnt     <= '0;
                        end else if (meas_tmo) begin
                            timeout <= 1'b1;
                            state   <= ARM;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef DIV_DETECT_LOCK_EN
    logic [1:0] match_cnt;
    logic [1:0] match_nxt;

    // div_out still holds the previous measurement when the new one is compared.
    always_comb begin
        match_nxt = 2'd0;
        if (cnt == div_out) match_nxt = (match_cnt == 2'd3) ? 2'd3 : match_cnt + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= 2'd0;
            locked    <= 1'b0;
        end else if (!en || meas_tmo) begin
            match_cnt <= 2'd0;
            locked    <= 1'b0;
        end else if (meas_upd) begin
            match_cnt <= match_nxt;
            locked    <= (match_nxt == 2'd3);
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_div_detect.sv
// Scoreboard bench for div_detect: a divider model drives clkd_in, expected div_out values are queued per scenario.
module tb_div_detect;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clkd_in;
    logic [10:0] div_out;
    logic        valid;
    logic        timeout;
    logic        busy;
    logic        locked;

    div_detect #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .en(en), .clkd_in(clkd_in),
        .div_out(div_out), .valid(valid), .timeout(timeout), .busy(busy), .locked(locked)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [10:0] exp_q[$];
    int          cyc = 0;
    int          nvalid = 0;
    int          last_vcyc = 0;
    int          last_gap = 0;
    logic        gen_on = 1'b0;
    int          gen_d = 0;
    int          hcnt = 0;

    // Divider model: toggles clkd_in every gen_d+1 clk cycles.
    initial begin
        clkd_in = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_on) begin
                hcnt++;
                if (hcnt > gen_d) begin
                    clkd_in = ~clkd_in;
                    hcnt = 0;
                end
            end else begin
                hcnt = 0;
            end
        end
    end

    // Scoreboard monitor: every valid pops one expected value; div_out must hold otherwise.
    initial begin
        logic [10:0] e;
        logic [10:0] prev_div;
        prev_div = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                if (valid) begin
                    nvalid++;
                    last_gap  = cyc - last_vcyc;
                    last_vcyc = cyc;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid: got div_out=%0d, scoreboard empty", div_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (div_out !== e) begin
                            errors++;
                            $display("FAIL div_out: got %0d expected %0d", div_out, e);
                        end
                    end
                end else begin
                    checks++;
                    if (div_out !== prev_div) begin
                        errors++;
                        $display("FAIL div_hold: div_out=%0d changed without valid (was %0d)", div_out, prev_div);
                    end
                end
            end
            prev_div = div_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: %0d results still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic stop_run();
        en     = 1'b0;
        gen_on = 1'b0;
        repeat (SYNC + 6) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        #2;
        chk("rst_div_out", 32'(div_out), 0);
        chk("rst_valid",   32'(valid),   0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_locked",  32'(locked),  0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_d5();
        gen_d  = 5;
        gen_on = 1'b1;
        repeat (6) exp_q.push_back(11'd5);
        en = 1'b1;
        @(posedge clk);
        #2;
        chk("d5_busy", 32'(busy), 1);
        wait_drain("d5", 200);
        chk("d5_gap", 32'(last_gap), 6);
        stop_run();
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic test_d0_switch();
        logic hit;
        gen_d  = 0;
        gen_on = 1'b1;
        repeat (12) exp_q.push_back(11'd0);
        en  = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == SYNC + 2) hit = 1'b1;
        end
        chk("d0_reached", 32'(hit), 1);
        chk("d0_gap", 32'(last_gap), 1);
        // Remaining zeros are edges already inside the synchronizer pipeline.
        gen_d = 2047;
        repeat (2) exp_q.push_back(11'd2047);
        wait_drain("d2047", 3 * 2048 + 100);
        chk("d2047_gap", 32'(last_gap), 2048);
        chk("d2047_timeout", 32'(timeout), 0);
        stop_run();
    endtask

    task automatic test_timeout();
        int t_cyc;
        gen_d  = 5;
        gen_on = 1'b1;
        repeat (2) exp_q.push_back(11'd5);
        en = 1'b1;
        wait_drain("tmo_pre", 200);
        gen_on = 1'b0;
        t_cyc  = -1;
        for (int i = 0; i < 2200 && t_cyc < 0; i++) begin
            @(posedge clk);
            #2;
            if (timeout) t_cyc = cyc;
        end
        chk("tmo_delay", 32'(t_cyc - last_vcyc), 2048);
        chk("tmo_busy", 32'(busy), 1);
        repeat (60) @(posedge clk);
        #2;
        chk("tmo_sticky", 32'(timeout), 1);
        chk("tmo_arm_busy", 32'(busy), 1);
        en = 1'b0;
        @(posedge clk);
        #2;
        chk("tmo_clear", 32'(timeout), 0);
        chk("tmo_idle_busy", 32'(busy), 0);
        stop_run();
    endtask

    task automatic test_en_drop();
        gen_d  = 100;
        gen_on = 1'b1;
        exp_q.push_back(11'd100);
        en = 1'b1;
        wait_drain("endrop_pre", 500);
        repeat (50) @(posedge clk);
        #2;
        en = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        chk("endrop_div_hold", 32'(div_out), 100);
        chk("endrop_timeout", 32'(timeout), 0);
        chk("endrop_busy", 32'(busy), 0);
        exp_q.push_back(11'd100);
        en = 1'b1;
        wait_drain("endrop_post", 600);
        chk("endrop_div_after", 32'(div_out), 100);
        stop_run();
    endtask

    task automatic test_rst_mid();
        gen_d  = 10;
        gen_on = 1'b1;
        exp_q.push_back(11'd10);
        en = 1'b1;
        wait_drain("rstmid_pre", 200);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_div_out", 32'(div_out), 0);
        chk("rstmid_valid",   32'(valid),   0);
        chk("rstmid_timeout", 32'(timeout), 0);
        chk("rstmid_busy",    32'(busy),    0);
        chk("rstmid_locked",  32'(locked),  0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(11'd10);
        wait_drain("rstmid_post", 200);
        chk("rstmid_div_after", 32'(div_out), 10);
        stop_run();
    endtask

    task automatic test_latency();
        logic lastv;
        logic seen;
        gen_d  = 19;
        gen_on = 1'b1;
        repeat (2) exp_q.push_back(11'd19);
        en   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 1) seen = 1'b1;
        end
        chk("lat_first_valid", 32'(seen), 1);
        lastv = clkd_in;
        seen  = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (clkd_in != lastv) seen = 1'b1;
        end
        chk("lat_toggle_seen", 32'(seen), 1);
        @(posedge clk);
        for (int i = 1; i <= SYNC + 2; i++) begin
            @(posedge clk);
            #2;
            if (i == SYNC + 1) chk("lat_early", 32'(valid), 0);
            if (i == SYNC + 2) chk("lat_valid", 32'(valid), 1);
        end
        wait_drain("lat", 10);
        stop_run();
    endtask

    task automatic wait_valid(output logic ok);
        int n0;
        n0 = nvalid;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (nvalid != n0) ok = 1'b1;
        end
    endtask

    task automatic test_lock();
        logic ok;
        gen_d  = 7;
        gen_on = 1'b1;
        repeat (4) exp_q.push_back(11'd7);
        en = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            wait_valid(ok);
            chk("lock7_valid_seen", 32'(ok), 1);
`ifdef DIV_DETECT_LOCK_EN
            chk("lock7_locked", 32'(locked), (n == 4) ? 1 : 0);
`else
            chk("lock7_locked_off", 32'(locked), 0);
`endif
        end
        gen_d = 8;
        repeat (4) exp_q.push_back(11'd8);
        for (int n = 1; n <= 4; n++) begin
            wait_valid(ok);
            chk("lock8_valid_seen", 32'(ok), 1);
`ifdef DIV_DETECT_LOCK_EN
            chk("lock8_locked", 32'(locked), (n == 4) ? 1 : 0);
`else
            chk("lock8_locked_off", 32'(locked), 0);
`endif
        end
        en = 1'b0;
        @(posedge clk);
        #2;
        chk("lock_clear_en", 32'(locked), 0);
        stop_run();
        chk("lock_queue_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        test_reset();
        test_d5();
        test_d0_switch();
        test_timeout();
        test_en_drop();
        test_rst_mid();
        test_latency();
        test_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
